// File: rtl/motor_drive_array.sv
// motor_drive_array
//   Multi-channel half-bridge gate drive core. A shared free-running PWM
//   counter defines the period. At each counter wrap, every channel latches
//   its signed duty word into shadow registers as a direction bit and a
//   saturated magnitude. A per-channel FSM turns the edge-aligned demand
//   (cnt < mag) into complementary high/low gate signals with dead time.
//   A latched driver fault forces all gates off.
//
// Optional feature (macro MOTOR_DRIVE_BRAKE_EN):
//   Adds the brake input. A set brake bit forces that channel's demand low,
//   so the channel settles in LOW once dead time has elapsed (low-side short
//   brake). Fault and enable still take precedence over brake.
//
// Parameters:
//   CHANNELS  number of half-bridge channels (>=1)
//   DUTY_W    width of each signed duty word
//   PWM_W     PWM counter width; period = 2**PWM_W cycles
//   DEADTIME  cycles with both gates off between transitions (>=1)
//
// Ports:
//   CLK           system clock
//   reset_n       asynchronous active-low reset
//   duty          signed duty per channel, channel i at [i*DUTY_W +: DUTY_W]
//   enable        per-channel enable
//   brake         per-channel low-side brake (MOTOR_DRIVE_BRAKE_EN only)
//   fault_n       driver FAULT_N pin, asynchronous, active low
//   fault_clear   single-cycle request to clear the latched fault
//   pwm_h/pwm_l   high-side / low-side gate drives
//   dir           direction, 1 = negative duty (valid from cnt == 0)
//   period_start  one-cycle pulse while the counter is 0
//   faulted       latched fault status
module motor_drive_array #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DUTY_W   = 24,
  parameter int unsigned PWM_W    = 10,
  parameter int unsigned DEADTIME = 16
) (
  input  logic                       CLK,
  input  logic                       reset_n,
  input  logic [CHANNELS*DUTY_W-1:0] duty,
  input  logic [CHANNELS-1:0]        enable,
`ifdef MOTOR_DRIVE_BRAKE_EN
  input  logic [CHANNELS-1:0]        brake,
`endif
  input  logic                       fault_n,
  input  logic                       fault_clear,
  output logic [CHANNELS-1:0]        pwm_h,
  output logic [CHANNELS-1:0]        pwm_l,
  output logic [CHANNELS-1:0]        dir,
  output logic                       period_start,
  output logic                       faulted
);

  localparam int unsigned DT_W = $clog2(DEADTIME + 1);
  localparam int unsigned AW   = (DUTY_W > PWM_W) ? DUTY_W : PWM_W;
  localparam logic [PWM_W-1:0] CNT_MAX   = '1;
  localparam logic [DT_W-1:0]  DT_RELOAD = DT_W'(DEADTIME - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DT_L,
    ST_LOW,
    ST_DT_H,
    ST_HIGH
  } state_t;

  // ---------------------------------------------------------------------
  // Shared counter, period pulse and fault latch
  // ---------------------------------------------------------------------
  logic [PWM_W-1:0] cnt_d, cnt_q;
  logic             period_start_d, period_start_q;
  logic             fault_meta_d, fault_meta_q;
  logic             fault_sync_d, fault_sync_q;
  logic             faulted_d, faulted_q;
  logic             wrap;

  assign wrap = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d          = cnt_q + PWM_W'(1);
    // Registered so the pulse lines up with cnt == 0 but stays low out of reset.
    period_start_d = wrap;
    fault_meta_d   = fault_n;
    fault_sync_d   = fault_meta_q;
    faulted_d      = faulted_q;
    // A fault seen on the same edge as a clear request wins.
    if (!fault_sync_q) begin
      faulted_d = 1'b1;
    end else if (fault_clear) begin
      faulted_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q          <= '0;
      period_start_q <= 1'b0;
      fault_meta_q   <= 1'b1;
      fault_sync_q   <= 1'b1;
      faulted_q      <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      period_start_q <= period_start_d;
      fault_meta_q   <= fault_meta_d;
      fault_sync_q   <= fault_sync_d;
      faulted_q      <= faulted_d;
    end
  end

  assign period_start = period_start_q;
  assign faulted      = faulted_q;

  // ---------------------------------------------------------------------
  // Per-channel shadow registers and gate FSM
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DUTY_W-1:0] duty_raw;
    logic              duty_neg;
    logic [DUTY_W-1:0] duty_abs;
    logic [AW-1:0]     abs_ext;
    logic [PWM_W-1:0]  mag_sat;
    logic [PWM_W-1:0]  mag_sh_d, mag_sh_q;
    logic              dir_sh_d, dir_sh_q;
    logic              dir_d, dir_q;
    logic              req;
    state_t            state_d, state_q;
    logic [DT_W-1:0]   dt_d, dt_q;
    logic              pwm_h_d, pwm_h_q;
    logic              pwm_l_d, pwm_l_q;

    assign duty_raw = duty[g*DUTY_W +: DUTY_W];

    always_comb begin
      duty_neg = duty_raw[DUTY_W-1];
      // Two's-complement negate; the most negative word becomes 2**(DUTY_W-1)
      // as an unsigned value, which then saturates like any large magnitude.
      duty_abs = duty_neg ? ('0 - duty_raw) : duty_raw;
      abs_ext  = AW'(duty_abs);
      mag_sat  = (abs_ext > AW'(CNT_MAX)) ? CNT_MAX : PWM_W'(abs_ext);

      mag_sh_d = mag_sh_q;
      dir_sh_d = dir_sh_q;
      if (wrap) begin
        mag_sh_d = mag_sat;
        dir_sh_d = duty_neg;
      end
      // Follows the shadow's next value so dir is already valid at cnt == 0.
      dir_d = dir_sh_d;
    end

`ifdef MOTOR_DRIVE_BRAKE_EN
    assign req = (cnt_q < mag_sh_q) & ~brake[g];
`else
    assign req = (cnt_q < mag_sh_q);
`endif

    always_comb begin
      state_d = state_q;
      dt_d    = dt_q;
      if (!enable[g] || faulted_q) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: state_d = ST_DT_L;
          ST_DT_L: begin
            if (req)              state_d = ST_HIGH;
            else if (dt_q == '0)  state_d = ST_LOW;
            else                  dt_d    = dt_q - DT_W'(1);
          end
          ST_LOW:  if (req) state_d = ST_DT_H;
          ST_DT_H: begin
            if (!req)             state_d = ST_LOW;
            else if (dt_q == '0)  state_d = ST_HIGH;
            else                  dt_d    = dt_q - DT_W'(1);
          end
          ST_HIGH: if (!req) state_d = ST_DT_L;
          default: state_d = ST_IDLE;
        endcase
      end
      // Dead-time counter reloads on entry, so each dead-time state lasts
      // exactly DEADTIME cycles unless demand cuts it short.
      if ((state_d == ST_DT_L && state_q != ST_DT_L) ||
          (state_d == ST_DT_H && state_q != ST_DT_H)) begin
        dt_d = DT_RELOAD;
      end
      pwm_h_d = (state_d == ST_HIGH);
      pwm_l_d = (state_d == ST_LOW);
    end

    always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
        mag_sh_q <= '0;
        dir_sh_q <= 1'b0;
        dir_q    <= 1'b0;
        state_q  <= ST_IDLE;
        dt_q     <= '0;
        pwm_h_q  <= 1'b0;
        pwm_l_q  <= 1'b0;
      end else begin
        mag_sh_q <= mag_sh_d;
        dir_sh_q <= dir_sh_d;
        dir_q    <= dir_d;
        state_q  <= state_d;
        dt_q     <= dt_d;
        pwm_h_q  <= pwm_h_d;
        pwm_l_q  <= pwm_l_d;
      end
    end

    // Gates drop in the same cycle the fault latches, ahead of the FSM
    // reaching IDLE on the following edge.
    assign pwm_h[g] = pwm_h_q & ~faulted_q;
    assign pwm_l[g] = pwm_l_q & ~faulted_q;
    assign dir[g]   = dir_q;
  end

endmodule

// File: tb/tb_motor_drive_array.sv
// Testbench for motor_drive_array (CHANNELS=2, PWM_W=8, DEADTIME=4).
// Stimulus pushes per-period expectations (gate on-counts, direction,
// overlap) into a scoreboard queue; a monitor accumulates per-period gate
// statistics and pops/compares at every period_start. Timing-critical
// events (reset, fault, enable) are checked directly in the stimulus.
module tb_motor_drive_array;
  localparam int unsigned CH = 2;
  localparam int unsigned DW = 24;
  localparam int unsigned PW = 8;
  localparam int unsigned DT = 4;

  logic           CLK = 1'b0;
  logic           reset_n;
  logic [CH*DW-1:0] duty;
  logic [CH-1:0]  enable;
  logic           fault_n;
  logic           fault_clear;
  logic [CH-1:0]  pwm_h;
  logic [CH-1:0]  pwm_l;
  logic [CH-1:0]  dir;
  logic           period_start;
  logic           faulted;
`ifdef MOTOR_DRIVE_BRAKE_EN
  logic [CH-1:0]  brake = '0;
`endif

  motor_drive_array #(
    .CHANNELS(CH),
    .DUTY_W  (DW),
    .PWM_W   (PW),
    .DEADTIME(DT)
  ) dut (
    .CLK         (CLK),
    .reset_n     (reset_n),
    .duty        (duty),
    .enable      (enable),
`ifdef MOTOR_DRIVE_BRAKE_EN
    .brake       (brake),
`endif
    .fault_n     (fault_n),
    .fault_clear (fault_clear),
    .pwm_h       (pwm_h),
    .pwm_l       (pwm_l),
    .dir         (dir),
    .period_start(period_start),
    .faulted     (faulted)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int   period;
    int   h0;
    int   l0;
    int   h1;
    int   l1;
    logic d0;
    logic d1;
  } exp_t;

  exp_t sb_q[$];
  int   errors    = 0;
  int   checks    = 0;
  int   period_no = 0;
  int   ovl_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input int p, input int h0, input int l0, input int h1,
                      input int l1, input logic d0, input logic d1);
    exp_t e;
    e.period = p; e.h0 = h0; e.l0 = l0; e.h1 = h1; e.l1 = l1; e.d0 = d0; e.d1 = d1;
    sb_q.push_back(e);
  endtask

  task automatic set_duty(input int ch, input int val);
    duty[ch*DW +: DW] = DW'(val);
  endtask

  // Advance to the next cycle with cnt == 0; cur = index of that period.
  task automatic wait_ps(output int cur);
    logic found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (period_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("period_start_seen", found, 1);
    cur = period_no + 1;
  endtask

  // Release reset and follow the first (partial) period up to the first wrap.
  task automatic release_and_sync(input string tag, output int cur);
    int ps_at = 0;
    int h_seen = 0;
    reset_n = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (pwm_h != '0) h_seen++;
      if (i == 1) check({tag, "_dir"}, dir, 0);
      if (i == 4) check({tag, "_l_before_dt"}, pwm_l, 0);
      if (i == 5) check({tag, "_l_after_dt"}, pwm_l, 3);
      if (period_start === 1'b1) begin
        ps_at = i;
        break;
      end
    end
    check({tag, "_first_wrap"}, ps_at, 256);
    check({tag, "_h_never"}, h_seen, 0);
    cur = period_no + 1;
  endtask

  // Monitor: per-period statistics, compared against the scoreboard.
  initial begin : monitor
    int   hc[CH];
    int   lc[CH];
    int   ov;
    logic dsmp[CH];
    bit   in_p;
    exp_t e;
    in_p = 1'b0;
    ov   = 0;
    for (int c = 0; c < CH; c++) begin hc[c] = 0; lc[c] = 0; dsmp[c] = 1'b0; end
    forever begin
      @(negedge CLK);
      if (reset_n !== 1'b1) begin
        in_p = 1'b0;
      end else begin
        if ((pwm_h & pwm_l) != '0) ovl_total++;
        if (period_start === 1'b1) begin
          if (in_p) begin
            while (sb_q.size() > 0 && sb_q[0].period < period_no) begin
              e = sb_q.pop_front();
              check("sb_period_order", e.period, period_no);
            end
            if (sb_q.size() > 0 && sb_q[0].period == period_no) begin
              e = sb_q.pop_front();
              check($sformatf("p%0d_h0_width", period_no), hc[0], e.h0);
              check($sformatf("p%0d_l0_width", period_no), lc[0], e.l0);
              check($sformatf("p%0d_h1_width", period_no), hc[1], e.h1);
              check($sformatf("p%0d_l1_width", period_no), lc[1], e.l1);
              check($sformatf("p%0d_dir0", period_no), dsmp[0], e.d0);
              check($sformatf("p%0d_dir1", period_no), dsmp[1], e.d1);
              check($sformatf("p%0d_overlap", period_no), ov, 0);
            end
          end
          period_no++;
          in_p = 1'b1;
          ov   = 0;
          for (int c = 0; c < CH; c++) begin
            hc[c] = 0; lc[c] = 0; dsmp[c] = dir[c];
          end
        end
        if (in_p) begin
          for (int c = 0; c < CH; c++) begin
            if (pwm_h[c] === 1'b1) hc[c]++;
            if (pwm_l[c] === 1'b1) lc[c]++;
            if (pwm_h[c] === 1'b1 && pwm_l[c] === 1'b1) ov++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cur;
    reset_n     = 1'b0;
    duty        = '0;
    enable      = 2'b11;
    fault_n     = 1'b1;
    fault_clear = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {pwm_h, pwm_l, dir, period_start, faulted}, 0);

    // Boot with duty 0: both channels settle in LOW.
    release_and_sync("boot", cur);
    push(cur, 0, 256, 0, 256, 1'b0, 1'b0);

    // ch0 = +64 from the next wrap: high 60, low 188.
    set_duty(0, 64);
    push(cur + 1, 60, 188, 0, 256, 1'b0, 1'b0);
    push(cur + 2, 60, 188, 0, 256, 1'b0, 1'b0);
    wait_ps(cur);
    wait_ps(cur);

    // ch1 = -300 saturates to 255 with dir=1; first period enters from LOW.
    set_duty(1, -300);
    push(cur + 1, 60, 188, 251, 1, 1'b0, 1'b1);
    push(cur + 2, 60, 188, 255, 0, 1'b0, 1'b1);
    wait_ps(cur);
    wait_ps(cur);

    // Mid-period duty change (cnt=100) only shows after the next wrap.
    repeat (100) tick();
    set_duty(0, 200);
    push(cur + 1, 196, 52, 255, 0, 1'b0, 1'b1);
    wait_ps(cur);
    wait_ps(cur);
    push(cur + 1, 196, 52, 255, 0, 1'b0, 1'b1);

    // Fault mid-HIGH at cnt=195, low for three cycles.
    repeat (195) tick();
    fault_n = 1'b0;
    tick();
    check("flt_t1_faulted", faulted, 0);
    tick();
    check("flt_t2_faulted", faulted, 0);
    check("flt_t2_h", pwm_h, 3);
    fault_clear = 1'b1;
    tick();
    check("flt_set_with_clear", faulted, 1);
    check("flt_gates_off", {pwm_h, pwm_l}, 0);
    fault_n = 1'b1;
    tick();
    check("flt_clear_blocked", faulted, 1);
    check("flt_gates_still_off", {pwm_h, pwm_l}, 0);
    fault_clear = 1'b0;
    repeat (2) tick();
    fault_clear = 1'b1;
    tick();
    check("flt_cleared", faulted, 0);
    fault_clear = 1'b0;
    tick();
    check("reenter_dt_l", {pwm_h, pwm_l}, 0);
    tick();
    check("reenter_ch1_high", pwm_h, 2'b10);
    check("reenter_l_off", pwm_l, 0);
    repeat (2) tick();
    check("reenter_ch0_dt4", pwm_l, 0);
    tick();
    check("reenter_ch0_low", pwm_l, 2'b01);
    check("reenter_h", pwm_h, 2'b10);
    wait_ps(cur);
    wait_ps(cur);

    // Asynchronous reset between edges while both high sides are on.
    repeat (20) tick();
    check("pre_rst_h", pwm_h, 3);
    #1 reset_n = 1'b0;
    #1 check("async_rst_outputs", {pwm_h, pwm_l, dir, period_start, faulted}, 0);
    repeat (3) tick();
    release_and_sync("rerun", cur);
    push(cur, 196, 52, 251, 1, 1'b0, 1'b1);
    push(cur + 1, 196, 52, 255, 0, 1'b0, 1'b1);
    wait_ps(cur);
    wait_ps(cur);

    // Dropping enable sends only that channel to IDLE on the next edge.
    repeat (10) tick();
    check("en_pre_h", pwm_h, 3);
    enable = 2'b01;
    tick();
    check("en_off_h", pwm_h, 2'b01);
    check("en_off_l", pwm_l, 0);
    repeat (3) tick();

    check("sb_drained", sb_q.size(), 0);
    check("no_overlap", ovl_total, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
